// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter that sequences NREQ requesters onto one shared combinational FPU.
// Optional build macro FPU_ARB_STICKY_FLAGS_EN adds clr_flags / sticky_flags flag accumulation.
//
// state | meaning
// IDLE  | round-robin search, accept one request, latch operands
// EXEC  | operands held on the FPU while the settle counter runs down
// RESP  | captured result presented until the consumer accepts it
module fpu_arbiter #(
  parameter int NREQ    = 4,
  parameter int FPU_LAT = 1,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_opA,
  input  logic [16*NREQ-1:0]   req_opB,
  input  logic [2*NREQ-1:0]    req_op,
  output logic [15:0]          fpu_opA,
  output logic [15:0]          fpu_opB,
  output logic [1:0]           fpu_op,
  input  logic [15:0]          fpu_result,
  input  logic                 fpu_underflow,
  input  logic                 fpu_overflow,
  input  logic                 fpu_inexact,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_result,
  output logic                 rsp_underflow,
  output logic                 rsp_overflow,
  output logic                 rsp_inexact,
`ifdef FPU_ARB_STICKY_FLAGS_EN
  input  logic                 clr_flags,
  output logic [2:0]           sticky_flags,
`endif
  output logic                 busy
);

  localparam int CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FPU_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [15:0]     opa_q, opa_d, opb_q, opb_d;
  logic [1:0]      op_q, op_d;
  logic [15:0]     res_q, res_d;
  logic [2:0]      flags_q, flags_d;

  logic [15:0]     opa_arr [NREQ];
  logic [15:0]     opb_arr [NREQ];
  logic [1:0]      op_arr  [NREQ];
  logic [IDW-1:0]  grant_id, cand;
  logic            grant_any, accept, capture;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign opa_arr[g] = req_opA[16*g +: 16];
    assign opb_arr[g] = req_opB[16*g +: 16];
    assign op_arr[g]  = req_op[2*g +: 2];
  end

  // Search starts just after the previous winner so simultaneous requesters rotate.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_q) + i) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign accept  = (state_q == S_IDLE) && grant_any;
  assign capture = (state_q == S_EXEC) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_any) state_d = S_EXEC;
      S_EXEC:  if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (accept) begin
      cnt_d  = CNT_INIT;
      last_d = grant_id;
      id_d   = grant_id;
      opa_d  = opa_arr[grant_id];
      opb_d  = opb_arr[grant_id];
      op_d   = op_arr[grant_id];
    end else if ((state_q == S_EXEC) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (capture) begin
      res_d   = fpu_result;
      flags_d = {fpu_underflow, fpu_overflow, fpu_inexact};
    end
  end

  // Ready is gated by reset so the reset value holds even while requests are pending.
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && grant_any && !reset) req_ready[grant_id] = 1'b1;
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
  end

  assign fpu_opA       = opa_q;
  assign fpu_opB       = opb_q;
  assign fpu_op        = op_q;
  assign rsp_id        = id_q;
  assign rsp_result    = res_q;
  assign rsp_underflow = flags_q[2];
  assign rsp_overflow  = flags_q[1];
  assign rsp_inexact   = flags_q[0];

`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;

  // A clear coinciding with a capture drops that capture's flags.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_flags)    sticky_d = '0;
    else if (capture) sticky_d = sticky_q | {fpu_underflow, fpu_overflow, fpu_inexact};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: table-driven and randomized checks of fpu_arbiter against a behavioural reference.
// Build with FPU_ARB_STICKY_FLAGS_EN defined to also exercise the sticky flag feature.
`timescale 1ns/1ps
module tb_fpu_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [63:0]     req_opA = '0, req_opB = '0;
  logic [7:0]      req_op = '0;
  logic [15:0]     fpu_opA, fpu_opB, fpu_result;
  logic [1:0]      fpu_op;
  logic            fpu_underflow, fpu_overflow, fpu_inexact;
  logic            rsp_valid, rsp_ready = 1'b0, busy;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_result;
  logic            rsp_underflow, rsp_overflow, rsp_inexact;
`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic            clr_flags = 1'b0;
  logic [2:0]      sticky_flags;
`endif

  logic [NREQ-1:0] r3_valid = '0, r3_ready;
  logic [63:0]     r3_opA = '0, r3_opB = '0;
  logic [7:0]      r3_op = '0;
  logic [15:0]     f3_opA, f3_opB, f3_result;
  logic [1:0]      f3_op;
  logic            f3_uf, f3_of, f3_ix;
  logic            rsp3_valid, rsp3_ready = 1'b0, busy3;
  logic [1:0]      rsp3_id;
  logic [15:0]     rsp3_result;
  logic            rsp3_uf, rsp3_of, rsp3_ix;
`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic [2:0]      sticky3;
`endif

  int tests = 0;
  int fails = 0;
  int m_last;

  // Stand-in for the shared FPU: two exact half-precision cases plus an arbitrary mixing function.
  function automatic logic [18:0] fpu_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    if (a == 16'h3C00 && b == 16'h4000 && op == 2'd0) return {3'b000, 16'h4200};
    if (a == 16'h7BFF && b == 16'h7BFF && op == 2'd0) return {3'b011, 16'h7C00};
    return {a[15] & b[15], a[3] & b[3], a[0] ^ b[0], a ^ {b[7:0], b[15:8]} ^ {14'd0, op}};
  endfunction

  // Round-robin reference: winner is the valid requester with the smallest rotational distance past last.
  function automatic int rr_pick(input logic [NREQ-1:0] vmask, input int last);
    int best = -1;
    int bestd = NREQ + 1;
    for (int id = 0; id < NREQ; id++) begin
      int d = (id - last - 1 + 2 * NREQ) % NREQ;
      if (vmask[id] && d < bestd) begin
        best = id;
        bestd = d;
      end
    end
    return best;
  endfunction

  assign {fpu_underflow, fpu_overflow, fpu_inexact, fpu_result} = fpu_model(fpu_opA, fpu_opB, fpu_op);
  assign {f3_uf, f3_of, f3_ix, f3_result} = fpu_model(f3_opA, f3_opB, f3_op);

  fpu_arbiter #(.NREQ(NREQ), .FPU_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opA(req_opA), .req_opB(req_opB), .req_op(req_op),
    .fpu_opA(fpu_opA), .fpu_opB(fpu_opB), .fpu_op(fpu_op),
    .fpu_result(fpu_result), .fpu_underflow(fpu_underflow),
    .fpu_overflow(fpu_overflow), .fpu_inexact(fpu_inexact),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_underflow(rsp_underflow),
    .rsp_overflow(rsp_overflow), .rsp_inexact(rsp_inexact),
`ifdef FPU_ARB_STICKY_FLAGS_EN
    .clr_flags(clr_flags), .sticky_flags(sticky_flags),
`endif
    .busy(busy)
  );

  fpu_arbiter #(.NREQ(NREQ), .FPU_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(r3_valid), .req_ready(r3_ready),
    .req_opA(r3_opA), .req_opB(r3_opB), .req_op(r3_op),
    .fpu_opA(f3_opA), .fpu_opB(f3_opB), .fpu_op(f3_op),
    .fpu_result(f3_result), .fpu_underflow(f3_uf),
    .fpu_overflow(f3_of), .fpu_inexact(f3_ix),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_id(rsp3_id),
    .rsp_result(rsp3_result), .rsp_underflow(rsp3_uf),
    .rsp_overflow(rsp3_of), .rsp_inexact(rsp3_ix),
`ifdef FPU_ARB_STICKY_FLAGS_EN
    .clr_flags(1'b0), .sticky_flags(sticky3),
`endif
    .busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete transaction on u_dut; called at a negedge, returns at a negedge with requests dropped.
  task automatic txn(input logic [NREQ-1:0] vmask, input int delay, input int exp_gid);
    int n, lat, gid;
    logic [18:0] exp;
    logic [15:0] ea;
    ea  = req_opA[16*exp_gid +: 16];
    exp = fpu_model(ea, req_opB[16*exp_gid +: 16], req_op[2*exp_gid +: 2]);
    req_valid = vmask;
    rsp_ready = 1'b0;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready == '0) begin
      chk("grant_timeout", 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    gid = -1;
    for (int r = 0; r < NREQ; r++) if (req_ready[r]) gid = r;
    chk("grant_onehot", $countones(req_ready), 32'd1);
    chk("grant_id", gid, exp_gid);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("exec_busy", busy, 1'b1);
        chk("exec_fpu_opA", fpu_opA, ea);
        chk("exec_req_ready", req_ready, '0);
        rsp_ready = (delay == 0);
      end
    end while (!rsp_valid && lat < 20);
    chk("rsp_latency", lat, 32'd2);
    chk("rsp_id", rsp_id, exp_gid);
    chk("rsp_result", rsp_result, exp[15:0]);
    chk("rsp_flags", {rsp_underflow, rsp_overflow, rsp_inexact}, exp[18:16]);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_stable", {rsp_id, rsp_result, rsp_underflow, rsp_overflow, rsp_inexact},
          {exp_gid[1:0], exp[15:0], exp[18:16]});
      chk("bp_req_ready", req_ready, '0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_done", rsp_valid, 1'b0);
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [NREQ-1:0] vmask;
    int              delay;
    int              exp_id;
    bit              special;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int n;
    logic [NREQ-1:0] vm;
    int e;
    bit seen;

    vecs[0]  = '{4'b1111, 0, 0, 1'b1};
    vecs[1]  = '{4'b1111, 0, 1, 1'b0};
    vecs[2]  = '{4'b1111, 0, 2, 1'b0};
    vecs[3]  = '{4'b1111, 1, 3, 1'b0};
    vecs[4]  = '{4'b1111, 0, 0, 1'b0};
    vecs[5]  = '{4'b1111, 0, 1, 1'b0};
    vecs[6]  = '{4'b1111, 2, 2, 1'b0};
    vecs[7]  = '{4'b1111, 0, 3, 1'b0};
    vecs[8]  = '{4'b0110, 5, 1, 1'b0};
    vecs[9]  = '{4'b0110, 0, 2, 1'b0};
    vecs[10] = '{4'b0001, 0, 0, 1'b0};
    vecs[11] = '{4'b1001, 0, 3, 1'b0};
    vecs[12] = '{4'b1001, 0, 0, 1'b0};
    vecs[13] = '{4'b0100, 0, 2, 1'b0};
    vecs[14] = '{4'b0011, 0, 0, 1'b0};
    vecs[15] = '{4'b1010, 0, 1, 1'b0};
    vecs[16] = '{4'b0010, 0, 1, 1'b0};
    vecs[17] = '{4'b1100, 0, 2, 1'b0};
    vecs[18] = '{4'b1100, 0, 3, 1'b0};
    vecs[19] = '{4'b1111, 2, 0, 1'b0};

    req_valid = 4'b1111;
    #12;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", {rsp_id, rsp_result, rsp_underflow, rsp_overflow, rsp_inexact}, '0);
    chk("rst_fpu_ops", {fpu_opA, fpu_opB, fpu_op}, '0);
    chk("rst3_outputs", {r3_ready, rsp3_valid, busy3, f3_opA}, '0);
`ifdef FPU_ARB_STICKY_FLAGS_EN
    chk("rst_sticky", sticky_flags, 3'b000);
`endif
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_req_ready", req_ready, '0);
    chk("idle_no_req_busy", busy, 1'b0);

    foreach (vecs[v]) begin
      for (int r = 0; r < NREQ; r++) begin
        req_opA[16*r +: 16] = 16'(v * 257 + r * 4096);
        req_opB[16*r +: 16] = 16'(v * 3 + r * 1024 + 32);
        req_op[2*r +: 2]    = 2'(v + r);
      end
      if (vecs[v].special) begin
        req_opA[15:0] = 16'h3C00;
        req_opB[15:0] = 16'h4000;
        req_op[1:0]   = 2'd0;
      end
      txn(vecs[v].vmask, vecs[v].delay, vecs[v].exp_id);
      if (vecs[v].special) chk("single_op_sum", rsp_result_hold(), 16'h4200);
    end

    // Reset while a response is pending: it must vanish and never reappear.
    req_opA[31:16] = 16'hBEEF;
    req_valid = 4'b0010;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rr_reset_grant", req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_rsp_valid", rsp_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_req_ready", req_ready, '0);
    chk("async_rst_regs", {rsp_id, rsp_result, fpu_opA}, '0);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_reset", seen, 1'b0);
    txn(4'b1001, 0, 0);
    m_last = 0;

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NREQ; r++) begin
        req_opA[16*r +: 16] = 16'($urandom);
        req_opB[16*r +: 16] = 16'($urandom);
        req_op[2*r +: 2]    = 2'($urandom);
      end
      vm = 4'($urandom_range(1, 15));
      e  = rr_pick(vm, m_last);
      txn(vm, int'($urandom_range(0, 3)), e);
      m_last = e;
    end

    // Settle window of 3 on the second instance.
    r3_opA[47:32] = 16'h5A5A;
    r3_opB[47:32] = 16'h1234;
    r3_op[5:4]    = 2'd3;
    r3_valid = 4'b0100;
    #1;
    n = 0;
    while (r3_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("lat3_grant", r3_ready, 4'b0100);
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) r3_valid = '0;
      chk("lat3_exec_no_rsp", rsp3_valid, 1'b0);
      chk("lat3_opA_held", f3_opA, 16'h5A5A);
      chk("lat3_busy", busy3, 1'b1);
    end
    @(negedge clk);
    chk("lat3_rsp_at_T4", rsp3_valid, 1'b1);
    chk("lat3_rsp_id", rsp3_id, 2'd2);
    chk("lat3_rsp_result", {rsp3_uf, rsp3_of, rsp3_ix, rsp3_result},
        fpu_model(16'h5A5A, 16'h1234, 2'd3));
    rsp3_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("lat3_rsp_done", rsp3_valid, 1'b0);
    rsp3_ready = 1'b0;

`ifdef FPU_ARB_STICKY_FLAGS_EN
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("sticky_cleared", sticky_flags, 3'b000);
    req_opA[15:0] = 16'h7BFF;
    req_opB[15:0] = 16'h7BFF;
    req_op[1:0]   = 2'd0;
    txn(4'b0001, 0, 0);
    chk("sticky_overflow", sticky_flags, 3'b011);
    req_opA[15:0] = 16'h3C00;
    req_opB[15:0] = 16'h4000;
    txn(4'b0001, 0, 0);
    chk("sticky_held", sticky_flags, 3'b011);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("sticky_clr_pulse", sticky_flags, 3'b000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // rsp_result is held in RESP and stays after the handshake until the next capture.
  function automatic logic [15:0] rsp_result_hold();
    return rsp_result;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shared-FPU request arbiter and sequencer. Accepts operation requests (operands plus opcode) from `NREQ` independent requesters over valid/ready handshakes and grants them round-robin. It holds the granted operands steady on the single combinational `fpu` instance for a fixed settle window, then captures the result and flags. The captured result is returned on one response channel, tagged with the requester index. It sits between operand sources (the `opmem` stream, future load/store or sequencer engines) and the `fpu` datapath.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `FPU_LAT`, 1, cycles the operands are held on the FPU before result capture (≥1)
- `IDW`, `$clog2(NREQ)`, requester-ID width (derived; do not override)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; at most one bit high
- `req_opA`  in  16*NREQ  operand A, requester i in bits [16i+15:16i]
- `req_opB`  in  16*NREQ  operand B, same packing
- `req_op`  in  2*NREQ  opcode, requester i in bits [2i+1:2i]
- `fpu_opA`, `fpu_opB`  out  16  operands driven to `fpu`
- `fpu_op`  out  2  opcode driven to `fpu`
- `fpu_result`  in  16  `fpu` result
- `fpu_underflow`, `fpu_overflow`, `fpu_inexact`  in  1  `fpu` flags
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer accept
- `rsp_id`  out  IDW  index of the requester that issued the op
- `rsp_result`  out  16  captured result
- `rsp_underflow`, `rsp_overflow`, `rsp_inexact`  out  1  captured flags
- `busy`  out  1  high in EXEC or RESP

## Operation
- FSM with three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Combinational round-robin grant: search starts at `last_grant+1` mod NREQ and selects the first requester with `req_valid` high.
  - `req_ready[winner]` is high; all other `req_ready` bits are low.
  - On the edge where a handshake occurs, latch that requester's opA, opB and op into operand registers, and record `last_grant` and `rsp_id`.
  - Next state is EXEC. Load the settle counter with `FPU_LAT-1`.
  - If no request is valid, stay in IDLE. `req_ready` is all zero.
- **EXEC**
  - Operand registers drive the `fpu_*` outputs (they drive them in every state).
  - The settle counter decrements each cycle.
  - On the cycle the counter equals 0, capture `fpu_result` and the three flags into the response registers. Next state is RESP.
- **RESP**
  - `rsp_valid` is high and the response registers are stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - Backpressure is unbounded. Hold RESP and the data unchanged while `rsp_ready` is low.
- `req_ready` is all zero outside IDLE. Requesters are expected to hold `req_valid` and data until accepted. Dropping `req_valid` before acceptance withdraws the request; this is legal.
- `last_grant` resets to NREQ-1, so requester 0 has first priority after reset.
- Opcodes are passed through unmodified. The arbiter does not interpret them.

## Timing
- Request handshake at edge T. EXEC occupies cycles T+1..T+FPU_LAT. `rsp_valid` is high from cycle T+FPU_LAT+1.
- Minimum issue interval is FPU_LAT+2 cycles, because the response handshake must occur before the next grant. There is no accept in the same cycle as the response.
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `busy`=0.
  - `rsp_id`=0, `rsp_result`=0, all `rsp_*` flags 0.
  - `fpu_opA`=`fpu_opB`=0, `fpu_op`=0.
- Reset asserted mid-EXEC or mid-RESP abandons the transaction; no response is ever produced for it. Outputs take their reset values asynchronously.
- A single valid requester is re-granted every round. Fairness applies only among simultaneously valid requesters.

## Configuration
- `FPU_ARB_STICKY_FLAGS_EN`
  - Defined: adds a `clr_flags` input (1 bit) and a `sticky_flags` output (3 bits, {underflow, overflow, inexact}).
    - Each response capture ORs the captured flags into `sticky_flags`.
    - `clr_flags` high clears it on the next edge. If `clr_flags` coincides with a capture, clear wins, and that capture's flags are lost.
    - Reset value is 0.
  - Undefined: neither port exists and there is no extra state.

## Test plan
- Single op: requester 0 sends opA=16'h3C00, opB=16'h4000, op=0, with `rsp_ready`=1 and FPU_LAT=1.
  - Response must appear 2 cycles after the handshake with `rsp_id`=0.
  - `rsp_result` must equal the `fpu` sum 16'h4200, with flags 0.
- Round-robin: all four requesters are held valid for 8 grants.
  - Grant order must be 0,1,2,3,0,1,2,3.
  - The `rsp_id` sequence must match the grant order.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while requesters 1 and 2 are valid.
  - `rsp_*` must stay constant.
  - `req_ready` must stay 0.
  - After release, the next grant goes to the next requester in round-robin order.
- Settle latency: set FPU_LAT=3. Response must appear at T+4, and `fpu_opA` must stay unchanged from T+1 to T+3.
- Reset during RESP: `rsp_valid` must drop immediately and no response is emitted afterwards. The first post-reset grant goes to requester 0 when requesters 0 and 3 are both valid.
- With `FPU_ARB_STICKY_FLAGS_EN` defined:
  - An overflowing op (opA=opB=16'h7BFF, op=0) must set `sticky_flags[1]`.
  - The flag must stay set across a following clean op.
  - Pulsing `clr_flags` must return it to 0.
